// File: rtl/mcu_strip_reader_if.sv
// ----------------------------------------------------------------------------
// mcu_strip_reader_if
//
// Groups the two buses of the strip reader:
//   * EBR read side: read_bank, read_block_select, read_addr and read_en go
//     out to the ping-pong buffer. ebr_rdata comes back one cycle after
//     read_en. It carries the packed dout of the 5 EBRs, with EBR k on
//     bits [8k+7:8k].
//   * Pixel stream: pix_data, pix_valid, mcu_first and mcu_last go to the
//     DCT front end. pix_ready is the sink's acceptance signal.
// The master modport is the reader. The slave modport is the memory/sink
// environment.
// ----------------------------------------------------------------------------
interface mcu_strip_reader_if;
    logic        read_bank;
    logic [2:0]  read_block_select;
    logic [8:0]  read_addr;
    logic        read_en;
    logic [39:0] ebr_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        mcu_first;
    logic        mcu_last;

    modport master (
        output read_bank, read_block_select, read_addr, read_en,
        output pix_data, pix_valid, mcu_first, mcu_last,
        input  ebr_rdata, pix_ready
    );

    modport slave (
        input  read_bank, read_block_select, read_addr, read_en,
        input  pix_data, pix_valid, mcu_first, mcu_last,
        output ebr_rdata, pix_ready
    );
endinterface

// File: rtl/mcu_strip_reader.sv
// ----------------------------------------------------------------------------
// mcu_strip_reader
//
// Drains one completed 8-line strip of 8x8 MCUs from the back bank of the
// ingester's image buffer. It streams the strip pixel by pixel, in MCU
// order, to the compression pipeline.
//
// Buffer layout:
//   * MCU n sits in EBR (n % NUM_EBRS) at slot (n / NUM_EBRS) % MCUS_PER_EBR.
//   * Each slot is 64 bytes, in row-major pixel order.
//
// Ports:
//   clock, nreset       system clock; synchronous active-low reset
//   frontbuffer_select  bank the ingester is writing (the other one is read)
//   strip_start         one-cycle pulse: back bank holds a full strip
//   strip_done          one-cycle pulse after the last pixel is accepted
//   overrun             sticky: strip_start seen while not idle
//   bus                 EBR read bus + pixel stream (mcu_strip_reader_if)
// ----------------------------------------------------------------------------
module mcu_strip_reader #(
    parameter int MCUS_PER_STRIP = 40,
    parameter int NUM_EBRS       = 5,
    parameter int MCUS_PER_EBR   = 8
) (
    input  logic clock,
    input  logic nreset,
    input  logic frontbuffer_select,
    input  logic strip_start,
    output logic strip_done,
    output logic overrun,
    mcu_strip_reader_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t      state_reg;
    logic [5:0]  pix_reg;
    logic [5:0]  mcu_reg;
    logic [2:0]  block_reg;
    logic [2:0]  slot_reg;
    logic        bank_reg;
    logic        strip_done_reg;
    logic        overrun_reg;

    // Read-return pipeline: mirrors a read issued last cycle whose data is on
    // ebr_rdata now.
    logic        ret_valid_reg;
    logic [2:0]  ret_block_reg;
    logic        ret_first_reg;
    logic        ret_last_reg;

    // 2-entry output FIFO; each entry is {mcu_first, mcu_last, pixel}.
    logic [9:0]  fifo_mem [0:1];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;

    logic        pop;
    logic [1:0]  occ_next;
    logic        read_en;
    logic        last_read;
    logic [9:0]  head;
    logic [7:0]  ebr_byte [0:7];

    // Unpack the EBR data bus into bytes. Unused block indices read as zero,
    // so a stray select can never index outside the bus.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            if (gi < NUM_EBRS) begin : g_used
                assign ebr_byte[gi] = bus.ebr_rdata[8*gi +: 8];
            end else begin : g_unused
                assign ebr_byte[gi] = 8'd0;
            end
        end
    endgenerate

    assign head = fifo_mem[rd_ptr_reg];
    assign pop  = (count_reg != 2'd0) && bus.pix_ready;

    // FIFO occupancy after this edge. It already includes the returning read
    // and this cycle's pop. That lets a new read be issued every cycle while
    // the sink keeps up, and still leaves room for its data next cycle.
    assign occ_next  = count_reg + {1'b0, ret_valid_reg} - {1'b0, pop};
    assign read_en   = (state_reg == S_READ) && (occ_next < 2'd2);
    assign last_read = (mcu_reg == 6'(MCUS_PER_STRIP - 1)) && (pix_reg == 6'd63);

    assign bus.read_en           = read_en;
    assign bus.read_bank         = bank_reg;
    assign bus.read_block_select = block_reg;
    assign bus.read_addr         = {slot_reg, pix_reg};
    assign bus.pix_valid         = (count_reg != 2'd0);
    assign bus.pix_data          = head[7:0];
    assign bus.mcu_first         = head[9] & bus.pix_valid;
    assign bus.mcu_last          = head[8] & bus.pix_valid;
    assign strip_done            = strip_done_reg;
    assign overrun               = overrun_reg;

    // FIFO storage is not reset: the pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (ret_valid_reg) begin
            fifo_mem[wr_ptr_reg] <= {ret_first_reg, ret_last_reg, ebr_byte[ret_block_reg]};
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_reg      <= S_IDLE;
            pix_reg        <= 6'd0;
            mcu_reg        <= 6'd0;
            block_reg      <= 3'd0;
            slot_reg       <= 3'd0;
            bank_reg       <= 1'b0;
            strip_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            ret_valid_reg  <= 1'b0;
            ret_block_reg  <= 3'd0;
            ret_first_reg  <= 1'b0;
            ret_last_reg   <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            count_reg      <= 2'd0;
        end else begin
            strip_done_reg <= 1'b0;
            if (strip_start && state_reg != S_IDLE) begin
                overrun_reg <= 1'b1;
            end

            // Block select and pixel position travel with the read to the
            // return cycle, where they pick the byte and tag the entry.
            ret_valid_reg <= read_en;
            if (read_en) begin
                ret_block_reg <= block_reg;
                ret_first_reg <= (pix_reg == 6'd0);
                ret_last_reg  <= (pix_reg == 6'd63);
            end

            if (ret_valid_reg) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= occ_next;

            case (state_reg)
                S_IDLE: begin
                    if (strip_start) begin
                        bank_reg  <= ~frontbuffer_select;
                        pix_reg   <= 6'd0;
                        mcu_reg   <= 6'd0;
                        block_reg <= 3'd0;
                        slot_reg  <= 3'd0;
                        state_reg <= S_READ;
                    end
                end
                S_READ: begin
                    if (read_en) begin
                        pix_reg <= pix_reg + 6'd1;
                        // Block and slot advance incrementally at each MCU
                        // boundary; no divide by NUM_EBRS is needed.
                        if (pix_reg == 6'd63) begin
                            mcu_reg <= mcu_reg + 6'd1;
                            if (block_reg == 3'(NUM_EBRS - 1)) begin
                                block_reg <= 3'd0;
                                slot_reg  <= (slot_reg == 3'(MCUS_PER_EBR - 1)) ?
                                             3'd0 : slot_reg + 3'd1;
                            end else begin
                                block_reg <= block_reg + 3'd1;
                            end
                        end
                        if (last_read) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // In DRAIN no read is issued. So once occ_next is zero,
                    // nothing is left in flight or in the FIFO.
                    if (occ_next == 2'd0) begin
                        strip_done_reg <= 1'b1;
                        state_reg      <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mcu_strip_reader.md
# mcu_strip_reader

Reads one completed 8-line strip of 8x8 MCUs out of the ingester's back-buffer EBR bank and streams it, pixel by pixel in MCU order, to the JPEG compression pipeline. It reads the same 5-EBR layout that `hm01b0_ingester` writes. It sits between the ping-pong image buffers and the DCT front end. It tells the top level when the back bank has been fully drained.

## Interface
Parameters:
- `MCUS_PER_STRIP`, 40: MCUs per 8-line strip (image width / 8).
- `NUM_EBRS`, 5: EBRs per bank; MCUs are interleaved across them.
- `MCUS_PER_EBR`, 8: 64-byte MCU slots per 512-byte EBR.

Ports:
- `clock`  in  1: system clock; all logic on rising edge.
- `nreset`  in  1: synchronous, active-low reset.
- `frontbuffer_select`  in  1: bank currently being written by the ingester.
- `strip_start`  in  1: one-cycle pulse; back bank holds a complete strip.
- `read_bank`  out  1: bank being read; latched as `~frontbuffer_select` when a strip is accepted.
- `read_block_select`  out  3: EBR index within the bank.
- `read_addr`  out  9: EBR read address.
- `read_en`  out  1: read strobe; EBR data returns on the next cycle.
- `ebr_rdata`  in  40: packed `dout` of the 5 EBRs; EBR k is on bits [8k+7:8k].
- `pix_data`  out  8: output pixel.
- `pix_valid`  out  1: `pix_data` is valid.
- `pix_ready`  in  1: the sink accepts the pixel when `pix_valid && pix_ready`.
- `mcu_first`  out  1: qualifies the pixel at index 0 of an MCU.
- `mcu_last`  out  1: qualifies the pixel at index 63 of an MCU.
- `strip_done`  out  1: one-cycle pulse after the last pixel of the strip is accepted.
- `overrun`  out  1: sticky; `strip_start` arrived while the reader was busy.

## Operation
- Memory map: MCU n (0..`MCUS_PER_STRIP`-1) lives in block `n % 5`.
  - Its base address is `((n / 5) % 8) * 64`.
  - Pixel index p (0..63, row-major, y*8+x) is at base+p.
- Read order: for MCU n = 0..39, read p = 0..63. That is 2560 reads per strip.
- FSM:
  - IDLE: waits for `strip_start`, then latches `read_bank`, clears the counters and goes to READ.
  - READ: issues reads subject to the credit rule. After the read for n=39, p=63 it goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then goes to DONE.
  - DONE: asserts `strip_done` for one cycle, then returns to IDLE.
- Output buffering: a 2-entry FIFO carries `pix_data`, `mcu_first` and `mcu_last`.
  - Credit rule: `read_en` is asserted only when (FIFO count + reads in flight) < 2.
  - `read_block_select` is registered along with `read_en` and selects the `ebr_rdata` byte on the return cycle.
- Counters: a 6-bit pixel counter and a 6-bit MCU counter.
  - The pixel counter wraps 63→0 and increments the MCU counter.
  - Block index and slot index are tracked incrementally: block wraps 4→0, and slot increments on each wrap.
  - Block and slot are not computed with a divider.
- `strip_start` outside IDLE is ignored and sets `overrun`. Only reset clears `overrun`.
- `strip_start` in DONE is also an overrun; a new strip is accepted only in IDLE.
- Pixel data passes through unmodified; level shifting is done elsewhere.

## Timing
- Reset values (from `nreset`=0 at an edge): state IDLE, counters 0, FIFO empty, in-flight cleared, `read_en`=0, `pix_valid`=0, `mcu_first`=0, `mcu_last`=0, `strip_done`=0, `overrun`=0, `read_bank`=0, `read_block_select`=0, `read_addr`=0.
- Reset asserted mid-strip: everything returns to reset values, no `strip_done` is emitted, and in-flight data is discarded.
- With `strip_start` at cycle T:
  - First `read_en` is at T+1.
  - The data is captured into the FIFO at T+2.
  - First `pix_valid` is at T+3.
- With `pix_ready` held at 1: one pixel per cycle sustained, with the last pixel at T+2562 and `strip_done` at T+2563.
- Under backpressure: no pixel is dropped or duplicated, and `pix_data` is stable while `pix_valid && !pix_ready`.
- `read_bank` does not change between acceptance and `strip_done`, even if `frontbuffer_select` toggles.

## Test plan
- Ascending pattern: preload bank 1 so that MCU n pixel p = (64n+p) mod 256, set `frontbuffer_select`=0, pulse `strip_start`, hold `pix_ready`=1.
  - Expect `read_bank`=1 and 2560 pixels 00,01,…,FF repeating.
  - Expect `mcu_first` on pixels 0,64,…; `mcu_last` on 63,127,…
  - Expect `strip_done` exactly at T+2563.
- Address mapping: check read address and block per MCU.
  - MCU 7 reads block 2, addresses 64..127.
  - MCU 39 reads block 4, addresses 448..511.
  - MCU 5 reads block 0, addresses 64..127.
- Backpressure: drive random `pix_ready` at 30% duty.
  - Expect the same 2560-pixel sequence, FIFO count never above 2, data stable while stalled, and `strip_done` one cycle after the final handshake.
- Overrun: pulse `strip_start` at pixel 1000.
  - Expect `overrun`=1 sticky, the strip to complete normally, and a later `strip_start` in IDLE to start a second strip.
- Reset mid-strip: deassert `nreset` for 1 cycle at pixel 500.
  - Expect all outputs at reset values next cycle and no `strip_done`.
  - A subsequent `strip_start` must deliver the full 2560 pixels starting at MCU 0, pixel 0.
